// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Byte width, legal operand-size bounds and the sequencer state encoding.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int BYTE_W = 8;
    localparam int NB_MIN = 1;
    localparam int NB_MAX = 16;

endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple adder with carry in and carry out.
// Shared byte-slice adder reused by the multi-precision sequencer.
module adder_8bit
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one shared 8-bit adder walks the operands
// LSB byte first, chaining the carry through a register.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    generate
        if (NBYTES < NB_MIN || NBYTES > NB_MAX) begin : g_bad_nbytes
            $error("mp_add_seq: NBYTES out of range");
        end
    endgenerate

    state_t                         state;
    logic [IW-1:0]                  idx;
    logic                           cy;
    logic [NBYTES-1:0][BYTE_W-1:0]  ar;
    logic [NBYTES-1:0][BYTE_W-1:0]  br;
    logic [NBYTES-1:0][BYTE_W-1:0]  sr;
    logic [BYTE_W-1:0]              s_byte;
    logic                           c_byte;

    adder_8bit u_add (
        .a    (ar[idx]),
        .b    (br[idx]),
        .cin  (cy),
        .sum  (s_byte),
        .cout (c_byte)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sr;
    assign cout      = cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cy    <= 1'b0;
            ar    <= '0;
            br    <= '0;
            sr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar    <= a;
                        br    <= b;
                        cy    <= cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sr[idx] <= s_byte;
                    cy      <= c_byte;
                    // idx holds at the top byte so it never leaves range
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq at NBYTES = 4, 2 and 1.
// Behavioural handshake/arithmetic model plus directed literal checks.
module tb_mp_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_i  [3];
    logic [31:0] b_i  [3];
    logic        ci   [3];
    logic        iv   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        co   [3];
    logic [31:0] sm   [3];
    logic [31:0] s4;
    logic [15:0] s2;
    logic [7:0]  s1;

    int nchk  = 0;
    int nfail = 0;
    bit run_chk = 1'b0;

    mp_add_seq #(.NBYTES(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(ci[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s4), .cout(co[0])
    );

    mp_add_seq #(.NBYTES(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_i[1][15:0]), .b(b_i[1][15:0]), .cin(ci[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s2), .cout(co[1])
    );

    mp_add_seq #(.NBYTES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_i[2][7:0]), .b(b_i[2][7:0]), .cin(ci[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s1), .cout(co[2])
    );

    assign sm[0] = s4;
    assign sm[1] = {16'd0, s2};
    assign sm[2] = {24'd0, s1};

    function automatic int nb(int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    // Full-width a+b+c, bit 8*n is the carry out
    function automatic logic [32:0] ref_add(int n, logic [31:0] x,
                                            logic [31:0] y, logic c);
        logic [32:0] m;
        m = (33'd1 << (8 * n)) - 33'd1;
        return ({1'b0, x} & m) + ({1'b0, y} & m) + {32'd0, c};
    endfunction

    function automatic logic [31:0] ref_sum(int n, logic [31:0] x,
                                            logic [31:0] y, logic c);
        logic [32:0] r;
        logic [32:0] m;
        r = ref_add(n, x, y, c);
        m = (33'd1 << (8 * n)) - 33'd1;
        return r[31:0] & m[31:0];
    endfunction

    function automatic logic ref_co(int n, logic [31:0] x,
                                    logic [31:0] y, logic c);
        logic [32:0] r;
        r = ref_add(n, x, y, c);
        return r[8 * n];
    endfunction

    task automatic chk(string nm, int k, logic [32:0] got,
                       logic [32:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t",
                     nm, k, got, exp, $time);
        end
    endtask

    task automatic tmo(string nm, int k);
        nchk++;
        nfail++;
        $display("FAIL %s dut=%0d timeout t=%0t", nm, k, $time);
    endtask

    // Model: busy from accept to result transfer, cnt = edges since accept
    logic        busy  [3];
    int          cnt   [3];
    logic [31:0] ex_s  [3];
    logic        ex_c  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                busy[k] <= 1'b0;
                cnt[k]  <= 0;
                ex_s[k] <= '0;
                ex_c[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!busy[k]) begin
                    if (iv[k]) begin
                        busy[k] <= 1'b1;
                        cnt[k]  <= 0;
                        ex_s[k] <= ref_sum(nb(k), a_i[k], b_i[k], ci[k]);
                        ex_c[k] <= ref_co(nb(k), a_i[k], b_i[k], ci[k]);
                    end
                end else if (cnt[k] < nb(k)) begin
                    cnt[k] <= cnt[k] + 1;
                end else if (ordy[k]) begin
                    busy[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_chk) begin
            for (int k = 0; k < 3; k++) begin
                chk("in_ready", k, ir[k], !busy[k]);
                chk("out_valid", k, ov[k], busy[k] && cnt[k] == nb(k));
                if (busy[k] && cnt[k] == nb(k)) begin
                    chk("sum", k, sm[k], ex_s[k]);
                    chk("cout", k, co[k], ex_c[k]);
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accept edge
    task automatic send(int k, logic [31:0] av, logic [31:0] bv,
                        logic c);
        int n;
        a_i[k] = av;
        b_i[k] = bv;
        ci[k]  = c;
        iv[k]  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[k]) break;
            n++;
            if (n > 100) begin
                tmo("send", k);
                break;
            end
        end
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    task automatic wait_out(int k, output logic [31:0] s,
                            output logic c, output int lat);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (ov[k]) break;
            if (n > 100) begin
                tmo("wait_out", k);
                break;
            end
        end
        s   = sm[k];
        c   = co[k];
        lat = n - 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog dut=0 timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic        c;
        logic [31:0] s_first;
        int          lat;
        int          gap;
        int          n;
        int          k;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_i[i]  = '0;
            b_i[i]  = '0;
            ci[i]   = 1'b0;
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, ir[i], 1'b1);
            chk("rst_out_valid", i, ov[i], 1'b0);
            chk("rst_sum", i, sm[i], 32'd0);
            chk("rst_cout", i, co[i], 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_chk = 1'b1;

        send(1, 32'h008D, 32'h0022, 1'b0);
        wait_out(1, s, c, lat);
        chk("t1_sum", 1, s, 32'h00AF);
        chk("t1_cout", 1, c, 1'b0);
        chk("t1_lat", 1, lat, 2);

        send(1, 32'h00FF, 32'h0082, 1'b0);
        wait_out(1, s, c, lat);
        chk("t2_sum", 1, s, 32'h0181);
        chk("t2_cout", 1, c, 1'b0);

        send(1, 32'hFFFF, 32'h0000, 1'b1);
        wait_out(1, s, c, lat);
        chk("t3_sum", 1, s, 32'h0000);
        chk("t3_cout", 1, c, 1'b1);

        ordy[0] = 1'b0;
        send(0, 32'h89ABCDEF, 32'h76543210, 1'b1);
        wait_out(0, s, c, lat);
        chk("t4_lat", 0, lat, 4);
        chk("t4_sum", 0, s, 32'h0);
        chk("t4_cout", 0, c, 1'b1);
        for (int i = 0; i < 5; i++) begin
            iv[0]  = ~iv[0];
            a_i[0] = $urandom;
            b_i[0] = $urandom;
            @(negedge clk);
            chk("t4_hold_in_ready", 0, ir[0], 1'b0);
            chk("t4_hold_valid", 0, ov[0], 1'b1);
            chk("t4_hold_sum", 0, sm[0], 32'h0);
            chk("t4_hold_cout", 0, co[0], 1'b1);
            @(posedge clk);
            #1;
        end
        a_i[0]  = 32'h10;
        b_i[0]  = 32'h20;
        ci[0]   = 1'b0;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_ready_rise", 0, ir[0], 1'b1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, s, c, lat);
        chk("t4_next_sum", 0, s, 32'h30);
        chk("t4_next_cout", 0, c, 1'b0);

        send(0, 32'h12345678, 32'h11111111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_in_ready", 0, ir[0], 1'b1);
        chk("t5_rst_valid", 0, ov[0], 1'b0);
        chk("t5_rst_sum", 0, sm[0], 32'h0);
        chk("t5_rst_cout", 0, co[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        wait_out(0, s, c, lat);
        chk("t5_sum", 0, s, 32'h0);
        chk("t5_cout", 0, c, 1'b1);

        a_i[2]  = 32'h0D;
        b_i[2]  = 32'h02;
        ci[2]   = 1'b0;
        ordy[2] = 1'b1;
        iv[2]   = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[2]) break;
            n++;
            if (n > 20) begin
                tmo("t6_first", 2);
                break;
            end
        end
        @(posedge clk);
        #1 ci[2] = 1'b1;
        gap = 0;
        s_first = '0;
        forever begin
            @(negedge clk);
            gap++;
            if (ov[2]) s_first = sm[2];
            if (ir[2]) break;
            if (gap > 20) begin
                tmo("t6_second", 2);
                break;
            end
        end
        @(posedge clk);
        #1 iv[2] = 1'b0;
        wait_out(2, s, c, lat);
        chk("t6_first_sum", 2, s_first, 32'h0F);
        chk("t6_second_sum", 2, s, 32'h10);
        chk("t6_gap", 2, gap, 3);
        chk("t6_lat", 2, lat, 1);

        for (int r = 0; r < 60; r++) begin
            k = r % 3;
            ordy[k] = ($urandom_range(0, 2) != 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(k,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                 1'($urandom_range(0, 1)));
            n = 0;
            forever begin
                @(negedge clk);
                if (ir[k]) break;
                n++;
                if (n > 200) begin
                    tmo("rand_done", k);
                    break;
                end
                @(posedge clk);
                #1 ordy[k] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk);
            #1 ordy[k] = 1'b1;
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
